// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: assembles little-endian words,
// writes them through a one-cycle port and gates core reset on a clean XOR checksum.
module imem_loader #(
  parameter int N  = 32,
  parameter int AW = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [7:0]    byte_in_i,
  input  logic          byte_valid_i,
  output logic          byte_ready_o,
  output logic          we_o,
  output logic [AW-1:0] waddr_o,
  output logic [N-1:0]  wdata_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          cpu_hold_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [7:0]    chk_q, chk_d;
  logic [N-1:0]  wdata_q, wdata_d;
  logic          fire;
  logic [AW:0]   idx_inc;

  assign fire    = byte_valid_i && byte_ready_o;
  assign idx_inc = idx_q + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      chk_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      chk_q   <= chk_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    chk_d   = chk_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_HDR;
          idx_d   = '0;
          bcnt_d  = '0;
          chk_d   = '0;
        end
      end
      S_HDR: begin
        if (fire) begin
          chk_d = byte_in_i;
          if (byte_in_i[7:6] != 2'b00) begin
            state_d = S_ERR;
          end else begin
            // A zero count field means a full-depth image.
            cnt_d   = (byte_in_i[AW-1:0] == '0) ? {1'b1, {AW{1'b0}}}
                                                : {1'b0, byte_in_i[AW-1:0]};
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (fire) begin
          wdata_d[8*bcnt_q +: 8] = byte_in_i;
          chk_d  = chk_q ^ byte_in_i;
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == cnt_q) ? S_CHK : S_DATA;
      end
      S_CHK: begin
        if (fire) state_d = (byte_in_i == chk_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign byte_ready_o = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
  assign we_o         = (state_q == S_WRITE);
  assign waddr_o      = idx_q[AW-1:0];
  assign wdata_o      = wdata_q;
  assign busy_o       = byte_ready_o || we_o;
  assign done_o       = (state_q == S_DONE);
  assign err_o        = (state_q == S_ERR);
  assign cpu_hold_o   = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: expected writes are queued from a stream-level
// model and popped by an independent write monitor.
module tb_imem_loader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [7:0]  byte_in_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        we_o;
  logic [5:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        busy_o, done_o, err_o, cpu_hold_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  stream[$];

  imem_loader #(.N(32), .AW(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .byte_in_i(byte_in_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .cpu_hold_o(cpu_hold_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every we pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (we_o === 1'b1) begin
      check("ready_low_in_write", {31'd0, byte_ready_o}, 32'd0);
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: addr %0d data %h, none expected", waddr_o, wdata_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("waddr", {26'd0, waddr_o}, {26'd0, e.addr});
        check("wdata", wdata_o, e.data);
      end
    end
    if (done_o === 1'b1 && err_o === 1'b1) begin
      total++; bad++;
      $display("FAIL done_err_exclusive: both high, expected at most one");
    end
  end

  // Stream-level model: returns 1 if the image should end in DONE, and queues writes.
  function automatic bit model(input logic [7:0] s[$]);
    int         n;
    logic [7:0] x;
    wr_t        w;
    if (s[0][7:6] != 2'b00) return 0;
    n = (s[0][5:0] == 0) ? 64 : int'(s[0][5:0]);
    x = s[0];
    for (int i = 0; i < n; i++) begin
      w.addr = 6'(i);
      w.data = {s[1+4*i+3], s[1+4*i+2], s[1+4*i+1], s[1+4*i]};
      exp_q.push_back(w);
      for (int k = 0; k < 4; k++) x ^= s[1+4*i+k];
    end
    return s[1+4*n] == x;
  endfunction

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit r;
    bit ok = 0;
    byte_in_i    = b;
    byte_valid_i = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk_i); r = byte_ready_o;
      @(posedge clk_i); ok = r;
    end
    #1 byte_valid_i = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL handshake_timeout: byte %h not accepted, expected acceptance", b);
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk_i);
      ok = !busy_o;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy still 1, expected 0");
    end
  endtask

  task automatic run_load(input string tag, input int max_stall, input bit stray);
    bit good;
    good = model(stream);
    pulse_start();
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i]);
      if (stray && i == 2) pulse_start();
      repeat ($urandom_range(max_stall, 0)) @(posedge clk_i);
      #1;
    end
    wait_idle();
    check({tag, "_done"}, {31'd0, done_o}, {31'd0, good});
    check({tag, "_err"}, {31'd0, err_o}, {31'd0, !good});
    check({tag, "_hold"}, {31'd0, cpu_hold_o}, {31'd0, !good});
    check({tag, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic set_t1(input logic [7:0] last);
    stream = '{8'h02, 8'h01, 8'h00, 8'h00, 8'hF8, 8'h02, 8'h80, 8'h00, 8'hF8, last};
  endtask

  initial begin
    logic [7:0] x;
    int         n;
    rst_i = 1'b1; start_i = 1'b0; byte_in_i = '0; byte_valid_i = 1'b0;
    #12;
    check("rst_ready", {31'd0, byte_ready_o}, 0);
    check("rst_we", {31'd0, we_o}, 0);
    check("rst_waddr", {26'd0, waddr_o}, 0);
    check("rst_wdata", wdata_o, 0);
    check("rst_flags", {29'd0, busy_o, done_o, err_o}, 0);
    check("rst_hold", {31'd0, cpu_hold_o}, 1);
    @(negedge clk_i); rst_i = 1'b0;
    @(posedge clk_i); #1;

    set_t1(8'h81); run_load("good2", 0, 0);
    check("good2_busy", {31'd0, busy_o}, 0);
    set_t1(8'h80); run_load("badchk", 0, 0);
    set_t1(8'h81); run_load("reload", 0, 0);

    stream = '{8'h00};
    x = 8'h00;
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = i;
      for (int k = 0; k < 4; k++) begin
        stream.push_back(w[8*k +: 8]);
        x ^= w[8*k +: 8];
      end
    end
    stream.push_back(x);
    run_load("full64", 0, 0);

    stream = '{8'h41};
    run_load("badhdr", 0, 0);
    check("badhdr_ready", {31'd0, byte_ready_o}, 0);

    set_t1(8'h81); run_load("stall", 3, 1);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(8, 1);
      stream = '{8'(n)};
      x = 8'(n);
      for (int i = 0; i < 4 * n; i++) begin
        stream.push_back(8'($urandom));
        x ^= stream[stream.size() - 1];
      end
      stream.push_back(($urandom_range(3, 0) == 0) ? ~x : x);
      run_load("rand", 2, 0);
    end

    // Reset after the 5th byte: the pending write must be abandoned.
    set_t1(8'h81);
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(stream[i]);
    rst_i = 1'b1;
    #1;
    check("midrst_we", {31'd0, we_o}, 0);
    check("midrst_flags", {29'd0, busy_o, done_o, err_o}, 0);
    check("midrst_hold", {31'd0, cpu_hold_o}, 1);
    check("midrst_wdata", wdata_o, 0);
    @(negedge clk_i); rst_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    check("postrst_ready", {31'd0, byte_ready_o}, 0);
    check("postrst_busy", {31'd0, busy_o}, 0);
    check("postrst_hold", {31'd0, cpu_hold_o}, 1);
    set_t1(8'h81); run_load("postrst", 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. Receives a program image as a byte stream over a valid/ready handshake and assembles 32-bit little-endian instruction words.
- Writes each word into a RAM-backed instruction memory through a one-cycle write port.
- Verifies an XOR checksum at the end of the image.
- Holds the LEGv8 core in reset (cpu_hold) until a complete, checksum-clean image is loaded.

Parameters:
- N, 32, instruction word width (fixed at 4 bytes).
- AW, 6, write address width; memory depth is 2**AW = 64 words.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERR
- byte_in  in  8  stream data byte
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  loader accepts a byte this cycle
- we  out  1  instruction memory write enable, one-cycle pulse
- waddr  out  AW  word address for the write
- wdata  out  N  assembled instruction word
- busy  out  1  load in progress (HDR, DATA, WRITE or CHK)
- done  out  1  last load completed with a good checksum
- err  out  1  last load failed (bad header or bad checksum)
- cpu_hold  out  1  keeps the core in reset; low only in DONE

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values: state=IDLE, byte_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, cpu_hold=1.
- Byte transfer: occurs on a rising edge with byte_valid=1 and byte_ready=1.
  - byte_ready is decoded from the state register only; there is no combinational path from byte_valid.
  - byte_ready=1 exactly in states HDR, DATA and CHK.
  - With byte_valid=0 the loader waits indefinitely; there is no timeout.
- FSM states and transitions:
  - IDLE: start -> HDR. Clears the word index, byte counter and checksum.
  - HDR: accepts one header byte H and initialises chk=H.
    - If H[7:6]!=0 -> ERR.
    - Otherwise count=H[5:0], with 0 meaning 64 words; go to DATA.
  - DATA: accepts 4 bytes; byte k (k=0..3) is placed in wdata[8k+7:8k]. Each accepted byte is XORed into chk. After the 4th byte -> WRITE.
  - WRITE: byte_ready=0; we=1 for exactly this cycle with waddr=index and a stable wdata. Next edge: index+1.
    - If index+1 == count, go to CHK; else go to DATA.
    - The index is compared in AW+1 bits so that count=64 terminates correctly. waddr never exceeds 63.
  - CHK: accepts one byte C. If C==chk -> DONE, else -> ERR.
  - DONE: done=1, cpu_hold=0. start -> HDR (reload), which also clears done and raises cpu_hold on the next edge.
  - ERR: err=1, cpu_hold=1. start -> HDR, which also clears err.
- Latency: we rises in the cycle after the edge that accepted the 4th byte of a word. Minimum load time is 1+5*count+1 handshake cycles after start.
- start is ignored in HDR, DATA, WRITE and CHK.
- busy=1 in HDR, DATA, WRITE and CHK; otherwise 0.
- done and err are mutually exclusive and never both 1.
- Reset mid-load: all outputs take their reset values immediately (asynchronous). Words already written remain in memory; the loader never clears memory. The core stays held.
- Words beyond count are not written and keep their previous contents.

Test Plan:
1. Good 2-word load: start; bytes 02, 01 00 00 F8, 02 80 00 F8, checksum 81 -> we pulses at waddr=0 with wdata=F8000001, then at waddr=1 with wdata=F8008002. Afterwards done=1, err=0, cpu_hold=0, busy=0.
2. Bad checksum: same stream with last byte 80 -> both writes occur, then err=1, done=0, cpu_hold=1. A following start plus the stream from test 1 ends with done=1.
3. Full depth: header 00, then 64 words where word i=i, checksum=XOR of all bytes -> 64 we pulses at waddr 0..63 in order, no 65th write, done=1.
4. Invalid header: header 41 -> err=1 on the next edge, we never asserts, byte_ready=0, cpu_hold=1.
5. Stalls and stray start: test 1 stream with 0-3 random idle cycles between bytes and a start pulse during DATA -> identical write sequence and done=1. Checks: byte_ready=0 in every WRITE cycle; no byte is consumed in WRITE.
6. Reset mid-load: assert reset after the 5th accepted byte of test 1 -> outputs take reset values asynchronously, no further we pulses. After release, state=IDLE and the loader waits for start.
